// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 emulator and the on-chip MCP3008 ADC driver.
package mcp3008_pkg;

  localparam int unsigned CMD_BITS   = 4;
  localparam int unsigned DATA_BITS  = 10;
  localparam int unsigned N_CHANNELS = 8;
  localparam int unsigned CH_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    NULLB,
    DATA,
    TRAIL
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, with registered 1-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic                  rise_q;
  logic                  fall_q;

  assign sync_o = sync_q[SyncStages-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SyncStages{ResetVal}};
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_o;
      rise_q <= sync_o & ~prev_q;
      fall_q <= ~sync_o & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/mcp3008_emulator.sv
// SPI responder emulating an MCP3008 ADC; serves fabric-loaded channel registers to an initiator.
module mcp3008_emulator
  import mcp3008_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SAMPLE_WIDTH = 10,
  parameter int unsigned N_CHANNELS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    axiiv,
  input  logic [SAMPLE_WIDTH-1:0] axiid,
  input  logic [CH_W-1:0]         axiich,
  input  logic                    spi_cs_n,
  input  logic                    spi_clk,
  input  logic                    spi_din,
  output logic                    spi_dout,
  output logic                    spi_dout_en,
  output logic                    axiov,
  output logic [CH_W-1:0]         axiod,
  output logic                    axiodiff
);

  localparam logic [1:0] CntLast = 2'(CMD_BITS - 1);
  localparam logic [3:0] IdxMsb  = 4'(DATA_BITS - 1);

  logic cs_sync, din_sync, sclk_rise, sclk_fall;
  logic cs_rise_unused, cs_fall_unused, din_rise_unused, din_fall_unused, sclk_sync_unused;

  // cs_n idles high, so its synchroniser resets to 1 to avoid a spurious select.
  sync_edge_detect #(.SyncStages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (spi_cs_n),
    .sync_o (cs_sync),
    .rise_o (cs_rise_unused),
    .fall_o (cs_fall_unused)
  );

  sync_edge_detect #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_din (
    .clk    (clk),
    .rst    (rst),
    .d_i    (spi_din),
    .sync_o (din_sync),
    .rise_o (din_rise_unused),
    .fall_o (din_fall_unused)
  );

  sync_edge_detect #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (spi_clk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  logic [SAMPLE_WIDTH-1:0] regs_q [N_CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (axiiv) begin
      regs_q[axiich] <= axiid;
    end
  end

  state_e                  state_q;
  logic [CMD_BITS-1:0]     cmd_q;
  logic [1:0]              cnt_q;
  logic [3:0]              idx_q;
  logic                    last_q;
  logic [SAMPLE_WIDTH-1:0] snap_q;
  logic                    dout_q, dout_en_q, axiov_q, axiodiff_q;
  logic [CH_W-1:0]         axiod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      snap_q     <= '0;
      dout_q     <= 1'b0;
      dout_en_q  <= 1'b0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      axiodiff_q <= 1'b0;
    end else begin
      axiov_q <= 1'b0;
      if (cs_sync) begin
        state_q   <= IDLE;
        dout_q    <= 1'b0;
        dout_en_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= START;
          START: begin
            if (sclk_rise && din_sync) begin
              state_q <= CMD;
              cnt_q   <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_q <= {cmd_q[CMD_BITS-2:0], din_sync};
              cnt_q <= cnt_q + 2'd1;
              // Register read sees the pre-write value if axiiv lands on this edge.
              if (cnt_q == CntLast) begin
                snap_q  <= regs_q[{cmd_q[1:0], din_sync}];
                state_q <= NULLB;
              end
            end
          end
          NULLB: begin
            if (sclk_fall) begin
              dout_en_q <= 1'b1;
              dout_q    <= 1'b0;
              idx_q     <= IdxMsb;
              last_q    <= 1'b0;
              state_q   <= DATA;
            end
          end
          DATA: begin
            if (sclk_fall) begin
              dout_q <= snap_q[idx_q];
              if (idx_q == 4'd0) begin
                last_q <= 1'b1;
              end else begin
                idx_q <= idx_q - 4'd1;
              end
            end else if (sclk_rise && last_q) begin
              axiov_q    <= 1'b1;
              axiod_q    <= cmd_q[CH_W-1:0];
              axiodiff_q <= cmd_q[CMD_BITS-1];
              state_q    <= TRAIL;
            end
          end
          TRAIL: begin
            if (sclk_fall) begin
              dout_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_dout    = dout_q;
  assign spi_dout_en = dout_en_q;
  assign axiov       = axiov_q;
  assign axiod       = axiod_q;
  assign axiodiff    = axiodiff_q;

endmodule

// File: tb/tb_mcp3008_emulator.sv
// Directed bench for mcp3008_emulator: drives an MCP3008-style initiator at 1 MHz SCLK.
module tb_mcp3008_emulator;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv;
  logic [9:0] axiid;
  logic [2:0] axiich;
  logic       spi_cs_n, spi_clk, spi_din;
  logic       spi_dout, spi_dout_en, axiov, axiodiff;
  logic [2:0] axiod;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         ov_cnt   = 0;
  logic [2:0] ov_ch    = '0;
  logic       ov_diff  = 1'b0;

  always #5 clk = ~clk;

  mcp3008_emulator #(
    .SYNC_STAGES  (2),
    .SAMPLE_WIDTH (10),
    .N_CHANNELS   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .axiich      (axiich),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .spi_dout_en (spi_dout_en),
    .axiov       (axiov),
    .axiod       (axiod),
    .axiodiff    (axiodiff)
  );

  always @(negedge clk) begin
    if (axiov === 1'b1) begin
      ov_cnt  = ov_cnt + 1;
      ov_ch   = axiod;
      ov_diff = axiodiff;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] ch, input logic [9:0] val);
    @(negedge clk);
    axiiv  = 1'b1;
    axiich = ch;
    axiid  = val;
    @(negedge clk);
    axiiv  = 1'b0;
  endtask

  // One SCLK period; samples dout/en at the rising edge. Optionally writes a register
  // on exactly the clk edge where the DUT acts on this rise.
  task automatic sclk_bit(input logic d, input bit wr, input logic [2:0] wch,
                          input logic [9:0] wval, output logic q, output logic en);
    spi_din = d;
    wait_neg(HALF);
    spi_clk = 1'b1;
    q  = spi_dout;
    en = spi_dout_en;
    if (wr) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      axiiv  = 1'b1;
      axiich = wch;
      axiid  = wval;
      @(negedge clk);
      axiiv  = 1'b0;
      wait_neg(HALF - 4);
    end else begin
      wait_neg(HALF);
    end
    spi_clk = 1'b0;
  endtask

  task automatic txn(input logic [2:0] ch, input logic sgl, input int nlead, input int nbits,
                     input bit wr, input logic [2:0] wch, input logic [9:0] wval,
                     output logic [9:0] data, output logic nullb, output logic en_early,
                     output logic en_null);
    logic       q, en;
    logic [4:0] cmd;
    cmd      = {1'b1, sgl, ch};
    data     = '0;
    en_early = 1'b0;
    spi_cs_n = 1'b0;
    wait_neg(10);
    for (int i = 0; i < nlead; i++) begin
      sclk_bit(1'b0, 1'b0, 3'd0, 10'd0, q, en);
      en_early = en_early | en;
    end
    for (int i = 4; i >= 0; i--) begin
      sclk_bit(cmd[i], wr && (i == 0), wch, wval, q, en);
      en_early = en_early | en;
    end
    sclk_bit(1'b0, 1'b0, 3'd0, 10'd0, nullb, en_null);
    for (int i = 9; i >= 10 - nbits; i--) begin
      sclk_bit(1'b0, 1'b0, 3'd0, 10'd0, q, en);
      data[i] = q;
    end
    if (nbits == 10) begin
      wait_neg(10);
      spi_cs_n = 1'b1;
      wait_neg(20);
    end
  endtask

  task automatic test_reset;
    wait_neg(3);
    n_checks++; if (spi_dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", spi_dout); else n_pass++;
    n_checks++; if (spi_dout_en !== 1'b0) $display("FAIL reset_en: got %b want 0", spi_dout_en); else n_pass++;
    n_checks++; if (axiov !== 1'b0) $display("FAIL reset_axiov: got %b want 0", axiov); else n_pass++;
    n_checks++; if (axiod !== 3'd0) $display("FAIL reset_axiod: got %0d want 0", axiod); else n_pass++;
    n_checks++; if (axiodiff !== 1'b0) $display("FAIL reset_axiodiff: got %b want 0", axiodiff); else n_pass++;
    rst = 1'b0;
    wait_neg(5);
  endtask

  task automatic test_basic;
    logic [9:0] d;
    logic       nb, ee, en;
    int         c0;
    write_reg(3'd5, 10'h2A7);
    c0 = ov_cnt;
    txn(3'd5, 1'b1, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (nb !== 1'b0) $display("FAIL basic_null: got %b want 0", nb); else n_pass++;
    n_checks++; if (d !== 10'h2A7) $display("FAIL basic_data: got %h want 2a7", d); else n_pass++;
    n_checks++; if (ee !== 1'b0) $display("FAIL basic_en_early: got %b want 0", ee); else n_pass++;
    n_checks++; if (en !== 1'b1) $display("FAIL basic_en_null: got %b want 1", en); else n_pass++;
    n_checks++; if (ov_cnt - c0 !== 1) $display("FAIL basic_ov_count: got %0d want 1", ov_cnt - c0); else n_pass++;
    n_checks++; if (ov_ch !== 3'd5) $display("FAIL basic_axiod: got %0d want 5", ov_ch); else n_pass++;
    n_checks++; if (ov_diff !== 1'b1) $display("FAIL basic_axiodiff: got %b want 1", ov_diff); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] d;
    logic       nb, ee, en;
    int         c0;
    write_reg(3'd0, 10'h3FF);
    write_reg(3'd7, 10'h001);
    c0 = ov_cnt;
    txn(3'd0, 1'b1, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h3FF) $display("FAIL b2b_ch0: got %h want 3ff", d); else n_pass++;
    n_checks++; if (ov_ch !== 3'd0) $display("FAIL b2b_axiod0: got %0d want 0", ov_ch); else n_pass++;
    // Differential request still returns the indexed register.
    txn(3'd7, 1'b0, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h001) $display("FAIL b2b_ch7: got %h want 001", d); else n_pass++;
    n_checks++; if (ov_ch !== 3'd7) $display("FAIL b2b_axiod7: got %0d want 7", ov_ch); else n_pass++;
    n_checks++; if (ov_diff !== 1'b0) $display("FAIL b2b_axiodiff: got %b want 0", ov_diff); else n_pass++;
    n_checks++; if (ov_cnt - c0 !== 2) $display("FAIL b2b_ov_count: got %0d want 2", ov_cnt - c0); else n_pass++;
  endtask

  task automatic test_leading_zeros;
    logic [9:0] d;
    logic       nb, ee, en;
    write_reg(3'd2, 10'h155);
    txn(3'd2, 1'b1, 3, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h155) $display("FAIL lead_data: got %h want 155", d); else n_pass++;
    n_checks++; if (ee !== 1'b0) $display("FAIL lead_en_early: got %b want 0", ee); else n_pass++;
    n_checks++; if (en !== 1'b1) $display("FAIL lead_en_null: got %b want 1", en); else n_pass++;
  endtask

  task automatic test_abort;
    logic [9:0] d;
    logic       nb, ee, en;
    int         c0;
    c0 = ov_cnt;
    txn(3'd5, 1'b1, 0, 4, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d[9:6] !== 4'b1010) $display("FAIL abort_partial: got %b want 1010", d[9:6]); else n_pass++;
    wait_neg(5);
    spi_cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (spi_dout_en !== 1'b0) $display("FAIL abort_en: got %b want 0", spi_dout_en); else n_pass++;
    wait_neg(20);
    n_checks++; if (ov_cnt - c0 !== 0) $display("FAIL abort_ov_count: got %0d want 0", ov_cnt - c0); else n_pass++;
    txn(3'd5, 1'b1, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h2A7) $display("FAIL abort_next: got %h want 2a7", d); else n_pass++;
    n_checks++; if (ov_cnt - c0 !== 1) $display("FAIL abort_next_ov: got %0d want 1", ov_cnt - c0); else n_pass++;
  endtask

  task automatic test_same_cycle_write;
    logic [9:0] d;
    logic       nb, ee, en;
    write_reg(3'd1, 10'h111);
    txn(3'd1, 1'b1, 0, 10, 1'b1, 3'd1, 10'h0F0, d, nb, ee, en);
    n_checks++; if (d !== 10'h111) $display("FAIL wr_same_old: got %h want 111", d); else n_pass++;
    txn(3'd1, 1'b1, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h0F0) $display("FAIL wr_same_new: got %h want 0f0", d); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [9:0] d;
    logic       nb, ee, en;
    int         c0;
    txn(3'd5, 1'b1, 0, 5, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    // Fifth data bit driven (bit 4 of 2A7 = 0); bit 5 was 1.
    n_checks++; if (d[9:5] !== 5'b10101) $display("FAIL rstmid_partial: got %b want 10101", d[9:5]); else n_pass++;
    wait_neg(8);
    n_checks++; if (spi_dout_en !== 1'b1) $display("FAIL rstmid_pre_en: got %b want 1", spi_dout_en); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (spi_dout_en !== 1'b0) $display("FAIL rstmid_en: got %b want 0", spi_dout_en); else n_pass++;
    n_checks++; if (axiov !== 1'b0) $display("FAIL rstmid_axiov: got %b want 0", axiov); else n_pass++;
    n_checks++; if (spi_dout !== 1'b0) $display("FAIL rstmid_dout: got %b want 0", spi_dout); else n_pass++;
    wait_neg(3);
    spi_cs_n = 1'b1;
    rst = 1'b0;
    wait_neg(10);
    c0 = ov_cnt;
    txn(3'd5, 1'b1, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h000) $display("FAIL rstmid_ch5: got %h want 000", d); else n_pass++;
    txn(3'd0, 1'b1, 0, 10, 1'b0, 3'd0, 10'd0, d, nb, ee, en);
    n_checks++; if (d !== 10'h000) $display("FAIL rstmid_ch0: got %h want 000", d); else n_pass++;
    n_checks++; if (ov_cnt - c0 !== 2) $display("FAIL rstmid_ov_count: got %0d want 2", ov_cnt - c0); else n_pass++;
  endtask

  initial begin
    rst      = 1'b1;
    axiiv    = 1'b0;
    axiid    = '0;
    axiich   = '0;
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    spi_din  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_leading_zeros();
    test_abort();
    test_same_cycle_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
